// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and frame-length helper.
// Used by uart_tx_frame and reusable by the matching receiver.
package uart_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Total clock cycles of one frame: start + data + optional parity + stop bits.
    function automatic int frame_len(input int data_w, input int parity,
                                     input int stop_bits, input int clks_per_bit);
        return (1 + data_w + parity + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side word handshake for uart_tx_frame; the parity-select signal exists
// only when UART_TX_PARITY_EN is defined.
interface uart_tx_frame_if #(
    parameter int DATA_W = 8
);
    logic              i_tx_valid;
    logic [DATA_W-1:0] i_tx_data;
`ifdef UART_TX_PARITY_EN
    logic              i_parity_odd;
`endif
    logic              o_tx_ready;

`ifdef UART_TX_PARITY_EN
    modport master (output i_tx_valid, output i_tx_data, output i_parity_odd,
                    input  o_tx_ready);
    modport slave  (input  i_tx_valid, input  i_tx_data, input  i_parity_odd,
                    output o_tx_ready);
`else
    modport master (output i_tx_valid, output i_tx_data, input  o_tx_ready);
    modport slave  (input  i_tx_valid, input  i_tx_data, output o_tx_ready);
`endif

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit. Synchronous clear restarts the period from zero.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = (r_cnt == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= w_at_max ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick  = i_enable && w_at_max;
    assign o_count = r_cnt;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine: start bit, DATA_W data bits LSB first, optional parity
// (UART_TX_PARITY_EN) and STOP_BITS stop bits, each CLKS_PER_BIT clocks long.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    uart_tx_frame_if.slave  bus,
    output logic            o_tx,
    output logic            o_busy,
    output logic            o_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    uart_state_e       r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;
    logic              r_ready;
`ifdef UART_TX_PARITY_EN
    logic              r_parity;
`endif

    logic              w_accept;
    logic              w_tick;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_last_bit;
    logic              w_last_stop;
    logic              w_pre_tick;

    assign w_accept    = bus.i_tx_valid && r_ready;
    assign w_last_bit  = (r_bit_cnt == BIT_W'(DATA_W - 1));
    assign w_last_stop = (r_bit_cnt == BIT_W'(STOP_BITS - 1));
    // One cycle before the bit boundary, so the registered o_done lands on the last cycle.
    assign w_pre_tick  = (w_cnt == CNT_W'(CLKS_PER_BIT - 2));

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_accept),
        .i_enable (r_busy),
        .o_tick   (w_tick),
        .o_count  (w_cnt)
    );

    // NOTE: the shift register is reset along with the control state; it is a
    // single register, not a memory, so the reset costs nothing and keeps it deterministic.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= LINE_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift   <= bus.i_tx_data;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= (^bus.i_tx_data) ^ bus.i_parity_odd;
`endif
                        r_bit_cnt <= '0;
                        r_tx      <= START_BIT;
                        r_busy    <= 1'b1;
                        r_ready   <= 1'b0;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (w_last_bit) begin
                            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            r_tx      <= r_parity;
                            r_state   <= PARITY;
`else
                            r_tx      <= LINE_IDLE;
                            r_state   <= STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_tx    <= LINE_IDLE;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_last_stop && w_pre_tick) begin
                        r_done <= 1'b1;
                    end
                    if (w_tick) begin
                        if (w_last_stop) begin
                            r_bit_cnt <= '0;
                            r_busy    <= 1'b0;
                            r_ready   <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_bit_cnt <= '0;
                    r_tx      <= LINE_IDLE;
                    r_busy    <= 1'b0;
                    r_ready   <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign o_tx           = r_tx;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign bus.o_tx_ready = r_ready;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: one 8-bit/1-stop instance and one 5-bit/2-stop
// instance, both at 4 clocks per bit. Honours UART_TX_PARITY_EN when defined.
module tb_uart_tx_frame;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB_A = 11;
    localparam int NB_B = 9;
`else
    localparam int NB_A = 10;
    localparam int NB_B = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_tx, a_busy, a_done;
    logic b_tx, b_busy, b_done;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_tx_frame_if #(.DATA_W(8)) if_a ();
    uart_tx_frame_if #(.DATA_W(5)) if_b ();

    uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
        .i_clk (clk), .i_reset (rst_n), .bus (if_a.slave),
        .o_tx (a_tx), .o_busy (a_busy), .o_done (a_done)
    );

    uart_tx_frame #(.DATA_W(5), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
        .i_clk (clk), .i_reset (rst_n), .bus (if_b.slave),
        .o_tx (b_tx), .o_busy (b_busy), .o_done (b_done)
    );

    // Expected line bits, index 0 first on the wire; parity value is supplied by the caller.
    function automatic logic [11:0] exp_a(input logic [7:0] d, input logic par);
`ifdef UART_TX_PARITY_EN
        return {1'b0, 1'b1, par, d, 1'b0};
`else
        return {2'b00, 1'b1, d, 1'b0} | {11'b0, par & 1'b0};
`endif
    endfunction

    function automatic logic [11:0] exp_b(input logic [4:0] d, input logic par);
`ifdef UART_TX_PARITY_EN
        return {2'b00, 2'b11, par, d, 1'b0};
`else
        return {3'b000, 2'b11, d, 1'b0} | {11'b0, par & 1'b0};
`endif
    endfunction

    function automatic logic [3:0] obs(input bit sel);
        return sel ? {b_tx, b_busy, if_b.o_tx_ready, b_done}
                   : {a_tx, a_busy, if_a.o_tx_ready, a_done};
    endfunction

    // Offers one word at a negedge; returns 1 ns after the accepting posedge.
    task automatic send(input bit sel, input logic [7:0] d, input logic odd, input bit keep);
        logic rdy;
        @(negedge clk);
        rdy = sel ? if_b.o_tx_ready : if_a.o_tx_ready;
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_err++;
            $display("FAIL ready_before_send: got %b expected 1", rdy);
        end
        if (sel) begin
            if_b.i_tx_valid = 1'b1;
            if_b.i_tx_data  = d[4:0];
`ifdef UART_TX_PARITY_EN
            if_b.i_parity_odd = odd;
`endif
        end else begin
            if_a.i_tx_valid = 1'b1;
            if_a.i_tx_data  = d;
`ifdef UART_TX_PARITY_EN
            if_a.i_parity_odd = odd;
`endif
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if_a.i_tx_valid = 1'b0;
            if_b.i_tx_valid = 1'b0;
        end
        if (odd === 1'bx) $display("odd select undefined");
    endtask

    // Called just after the accept edge: checks {tx,busy,ready,done} on every cycle of
    // the frame, then the single idle cycle that follows it.
    task automatic check_frame(input bit sel, input logic [11:0] bits, input int nbits,
                               input string name);
        int         f;
        logic [3:0] got, want;
        f = nbits * CPB;
        for (int k = 1; k <= f + 1; k++) begin
            @(negedge clk);
            got  = obs(sel);
            want = (k <= f) ? {bits[(k - 1) / CPB], 1'b1, 1'b0, (k == f)} : 4'b1010;
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s cycle %0d: got tx/busy/ready/done=%b expected %b",
                         name, k, got, want);
            end
        end
    endtask

    task automatic check_idle(input int cycles, input string name);
        logic [3:0] got;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            got = obs(1'b0);
            n_cmp++;
            if (got !== 4'b1010) begin
                n_err++;
                $display("FAIL %s cycle %0d: got tx/busy/ready/done=%b expected 1010",
                         name, k, got);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs(1'b0) !== 4'b1010) begin
            n_err++;
            $display("FAIL reset_a: got %b expected 1010", obs(1'b0));
        end
        n_cmp++;
        if (obs(1'b1) !== 4'b1010) begin
            n_err++;
            $display("FAIL reset_b: got %b expected 1010", obs(1'b1));
        end
        rst_n = 1'b1;
        check_idle(3, "idle_after_reset");
    endtask

    task automatic test_frame();
        send(1'b0, 8'hA5, 1'b0, 1'b0);
        check_frame(1'b0, exp_a(8'hA5, 1'b0), NB_A, "frame_a5");
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        send(1'b0, 8'hA5, 1'b0, 1'b0);
        check_frame(1'b0, exp_a(8'hA5, 1'b0), NB_A, "parity_even_a5");
        send(1'b0, 8'hA5, 1'b1, 1'b0);
        check_frame(1'b0, exp_a(8'hA5, 1'b1), NB_A, "parity_odd_a5");
    endtask
`endif

    task automatic test_back_to_back();
        send(1'b0, 8'h3C, 1'b0, 1'b1);
        if_a.i_tx_data = 8'hC3;
        check_frame(1'b0, exp_a(8'h3C, 1'b0), NB_A, "b2b_first");
        @(posedge clk);
        #1;
        if_a.i_tx_valid = 1'b0;
        check_frame(1'b0, exp_a(8'hC3, 1'b0), NB_A, "b2b_second");
    endtask

    task automatic test_ignore_busy();
        send(1'b0, 8'h81, 1'b0, 1'b0);
        fork
            check_frame(1'b0, exp_a(8'h81, 1'b0), NB_A, "ignore_busy");
            begin
                repeat (10) @(negedge clk);
                #1;
                if_a.i_tx_valid = 1'b1;
                if_a.i_tx_data  = 8'hFF;
                repeat (2) @(negedge clk);
                #1;
                if_a.i_tx_valid = 1'b0;
            end
        join
    endtask

    task automatic test_reset_mid_frame();
        send(1'b0, 8'hA5, 1'b0, 1'b0);
        repeat (13) @(negedge clk);
        n_cmp++;
        if (obs(1'b0) !== 4'b1100) begin
            n_err++;
            $display("FAIL mid_frame_bit2: got %b expected 1100", obs(1'b0));
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs(1'b0) !== 4'b1010) begin
            n_err++;
            $display("FAIL async_reset: got %b expected 1010", obs(1'b0));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_idle(8, "no_resume");
        send(1'b0, 8'h55, 1'b0, 1'b0);
        check_frame(1'b0, exp_a(8'h55, 1'b0), NB_A, "after_reset_55");
    endtask

    task automatic test_reset_at_accept();
        @(negedge clk);
        if_a.i_tx_valid = 1'b1;
        if_a.i_tx_data  = 8'h99;
        rst_n = 1'b0;
        @(negedge clk);
        if_a.i_tx_valid = 1'b0;
        rst_n = 1'b1;
        check_idle(6, "reset_at_accept");
    endtask

    task automatic test_two_stop();
        send(1'b1, 8'h1F, 1'b0, 1'b0);
        check_frame(1'b1, exp_b(5'h1F, 1'b1), NB_B, "two_stop_1f");
    endtask

    initial begin
        if_a.i_tx_valid = 1'b0;
        if_a.i_tx_data  = '0;
        if_b.i_tx_valid = 1'b0;
        if_b.i_tx_data  = '0;
`ifdef UART_TX_PARITY_EN
        if_a.i_parity_odd = 1'b0;
        if_b.i_parity_odd = 1'b0;
`endif
        test_reset();
        test_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        test_reset_at_accept();
        test_two_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit engine: accepts a parallel word over a valid/ready handshake and serialises it as start bit, data bits (LSB first), optional parity bit and one or two stop bits, each held for a fixed number of clock cycles. It replaces the fixed 8-bit transmit FSM plus external counter/mux with one self-contained block that owns bit timing, shifting and line-level selection. It sits between the host-side register interface and the TX pad.

## Interface
- DATA_W, 8, data bits per frame; legal 5..9
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal >= 2
- STOP_BITS, 1, stop bits per frame; legal 1 or 2
- i_clk  input  1  system clock, all logic on rising edge
- i_reset  input  1  asynchronous, active-low reset
- i_tx_valid  input  1  host offers a word
- i_tx_data  input  DATA_W  word to transmit
- i_parity_odd  input  1  parity select, 1 = odd, 0 = even (present only with UART_TX_PARITY_EN)
- o_tx_ready  output  1  block can accept a word
- o_tx  output  1  serial line, idle high
- o_busy  output  1  frame in progress
- o_done  output  1  one-cycle pulse at frame end

## Operation
- Reset values: o_tx=1, o_tx_ready=1, o_busy=0, o_done=0, state IDLE, counters 0.
- Accept when i_tx_valid && o_tx_ready; i_tx_data and i_parity_odd latched that cycle; later changes ignored.
- o_tx_ready high only in IDLE; i_tx_valid while busy has no effect.
- States: IDLE -> START (on accept) -> DATA -> PARITY (macro on) or STOP -> IDLE.
- START: o_tx=0 for CLKS_PER_BIT cycles.
- DATA: shift register drives bit 0 first; bit counter 0..DATA_W-1; leaves DATA when last bit period ends.
- PARITY: o_tx = XOR of latched data, inverted when odd selected.
- STOP: o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Baud counter counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, reset to 0 on accept; width $clog2(CLKS_PER_BIT).
- Unreachable state encodings return to IDLE with o_tx=1.

## Timing
- o_tx, o_busy, o_done registered. Accept in cycle N -> o_tx=0, o_busy=1 from cycle N+1.
- Frame length F = (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT cycles, P=1 with macro else 0.
- o_done high in final cycle of last stop bit (cycle N+F); o_busy low and o_tx_ready high from N+F+1.
- Back-to-back: i_tx_valid held high -> next accept at N+F+1, next start bit at N+F+2; exactly one idle-high cycle between frames.
- Reset asserted mid-frame: o_tx=1, o_busy=0, o_done=0 immediately (asynchronous); no partial frame resumes after release.
- Reset coinciding with accept: reset wins, word dropped.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state compiled in, i_parity_odd port present, P=1.
- Undefined: no parity state or port, DATA goes directly to STOP, P=0.

## Structure
- Shared package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), 3-bit state width, line-level constants (LINE_IDLE=1, START_BIT=0), frame-length function.
- Sub-module uart_baud_tick: CLKS_PER_BIT counter with clear input and bit-boundary tick output, reusable by the receiver.

## Test plan
- DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1, no parity, send 0xA5 -> o_tx bits 0,1,0,1,0,0,1,0,1,1 each 4 cycles, o_done at cycle 40 after accept.
- Macro on, send 0xA5 even -> parity bit 0; odd -> parity bit 1; frame 44 cycles.
- i_tx_valid held high with 0x3C then 0xC3 -> two frames separated by exactly one idle cycle, o_done pulses twice.
- i_tx_valid pulsed during DATA with 0xFF -> ignored, in-flight frame unchanged, o_tx_ready stays 0.
- Reset asserted in 3rd data bit -> o_tx=1, o_busy=0 same cycle; after release, new 0x55 frame correct.
- STOP_BITS=2, DATA_W=5, send 0x1F -> stop high for 2*CLKS_PER_BIT cycles, F=8*CLKS_PER_BIT.
